// File: rtl/encrypt_load_pkg.sv
// Shared block/key/round parameters and FSM state encoding for the encrypt_load front end.
package encrypt_load_pkg;

  localparam int unsigned N_B_DEF = 64;
  localparam int unsigned N_K_DEF = 80;
  localparam int unsigned N_R_DEF = 31;
  localparam int unsigned NBB_DEF = N_B_DEF / 8;
  localparam int unsigned NKB_DEF = N_K_DEF / 8;

  typedef enum logic [1:0] {
    ST_KEY   = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/encrypt_load_tag.sv
// Single-bit token delay line; a token entering at i_tok leaves o_tok DEPTH cycles later.
module encrypt_load_tag #(
  parameter int unsigned DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tok,
  output logic o_tok
);

  logic [DEPTH-1:0] r_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_line <= '0;
    else     r_line <= DEPTH'({r_line, i_tok});
  end

  assign o_tok = r_line[DEPTH-1];

endmodule

// File: rtl/encrypt_load.sv
// Byte-stream loader for key and plaintext feeding encrypt_pipe; tracks issued blocks to r_valid.
// ENCRYPT_LOAD_LE_EN: when defined, the first byte lands in bits [7:0] instead of the MSB.
module encrypt_load
  import encrypt_load_pkg::*;
#(
  parameter int unsigned N_B = N_B_DEF,
  parameter int unsigned N_K = N_K_DEF,
  parameter int unsigned N_R = N_R_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     d,
  input  logic           d_valid,
  output logic           d_ready,
  input  logic           kld,
  output logic [N_K-1:0] k,
  output logic [N_B-1:0] m,
  output logic           issue,
  input  logic [N_B-1:0] c,
  output logic [N_B-1:0] r,
  output logic           r_valid
);

  localparam int unsigned NBB  = N_B / 8;
  localparam int unsigned NKB  = N_K / 8;
  localparam int unsigned NMAX = (NKB > NBB) ? NKB : NBB;
  localparam int unsigned CW   = $clog2(NMAX + 1);

  state_e         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt, w_cnt_base;
  logic           r_pend, w_pend_nxt, w_kld, w_key_mode;
  logic [N_K-1:0] r_ksh, w_ksh_nxt, w_ksh_in, r_k, w_k_nxt;
  logic [N_B-1:0] r_msh, w_msh_nxt, w_msh_in, r_m, w_m_nxt;
  logic           r_issue, w_issue_nxt, r_d_ready, w_d_ready_nxt;

`ifdef ENCRYPT_LOAD_LE_EN
  assign w_ksh_in = N_K'({d, r_ksh} >> 8);
  assign w_msh_in = N_B'({d, r_msh} >> 8);
`else
  assign w_ksh_in = N_K'({r_ksh, d});
  assign w_msh_in = N_B'({r_msh, d});
`endif

  // A pending reload takes effect only between messages, never splitting a partial block.
  assign w_kld      = r_pend | kld;
  assign w_key_mode = (r_state == ST_KEY) ||
                      ((r_state == ST_FILL) && (r_cnt == '0) && w_kld);
  assign w_cnt_base = ((r_state == ST_KEY) && kld) ? '0 : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_KEY;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_ksh     <= '0;
      r_msh     <= '0;
      r_k       <= '0;
      r_m       <= '0;
      r_issue   <= 1'b0;
      r_d_ready <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_ksh     <= w_ksh_nxt;
      r_msh     <= w_msh_nxt;
      r_k       <= w_k_nxt;
      r_m       <= w_m_nxt;
      r_issue   <= w_issue_nxt;
      r_d_ready <= w_d_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = w_kld;
    w_ksh_nxt   = r_ksh;
    w_msh_nxt   = r_msh;
    w_k_nxt     = r_k;
    w_m_nxt     = r_m;
    if (w_key_mode) begin
      w_state_nxt = ST_KEY;
      w_pend_nxt  = 1'b0;
      w_cnt_nxt   = w_cnt_base;
      if (d_valid) begin
        w_ksh_nxt = w_ksh_in;
        if (w_cnt_base == CW'(NKB - 1)) begin
          w_k_nxt     = w_ksh_in;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FILL;
        end else begin
          w_cnt_nxt = w_cnt_base + CW'(1);
        end
      end
    end else begin
      case (r_state)
        ST_FILL: begin
          if (d_valid) begin
            w_msh_nxt = w_msh_in;
            if (r_cnt == CW'(NBB - 1)) begin
              w_m_nxt     = w_msh_in;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_ISSUE;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (w_kld) begin
            w_state_nxt = ST_KEY;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
        default: w_state_nxt = ST_KEY;
      endcase
    end
    w_issue_nxt   = (w_state_nxt == ST_ISSUE);
    w_d_ready_nxt = (w_state_nxt != ST_ISSUE);
  end

  encrypt_load_tag #(
    .DEPTH (N_R + 1)
  ) u_tag (
    .clk   (clk),
    .rst   (rst),
    .i_tok (r_issue),
    .o_tok (r_valid)
  );

  assign d_ready = r_d_ready;
  assign issue   = r_issue;
  assign k       = r_k;
  assign m       = r_m;
  assign r       = c;

endmodule

// File: tb/tb_encrypt_load.sv
// Randomised scoreboard bench for encrypt_load against a byte-queue reference model.
module tb_encrypt_load;

  localparam int unsigned N_B = 64;
  localparam int unsigned N_K = 80;
  localparam int unsigned N_R = 31;
  localparam int unsigned NBB = N_B / 8;
  localparam int unsigned NKB = N_K / 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     d = '0;
  logic           d_valid = 1'b0;
  logic           kld = 1'b0;
  logic           d_ready, issue, r_valid;
  logic [N_K-1:0] k;
  logic [N_B-1:0] m, r;
  logic [N_B-1:0] c = '0;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [N_K-1:0] k;
    logic [N_B-1:0] m;
    int             cyc;
  } exp_t;

  exp_t issue_q[$];
  int   rv_q[$];
  exp_t e;
  int   cyc = 0, n_chk = 0, n_fail = 0, rel_cyc = 0;

  bit             m_issue, m_loadkey, m_pend;
  bq_t            key_q, msg_q;
  logic [N_K-1:0] m_k;
  logic [N_B-1:0] m_m;

  encrypt_load #(.N_B(N_B), .N_K(N_K), .N_R(N_R)) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .kld(kld), .k(k), .m(m), .issue(issue), .c(c), .r(r), .r_valid(r_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] pack(input bq_t q);
    logic [127:0] v = '0;
    for (int i = 0; i < q.size(); i++) begin
`ifdef ENCRYPT_LOAD_LE_EN
      v = v | (128'(q[i]) << (8 * i));
`else
      v = (v << 8) | 128'(q[i]);
`endif
    end
    return v;
  endfunction

  task automatic model_reset();
    m_issue = 0; m_loadkey = 1; m_pend = 0;
    key_q.delete(); msg_q.delete();
    m_k = '0; m_m = '0;
    issue_q.delete(); rv_q.delete();
  endtask

  // Advance the reference model by one cycle given this cycle's inputs.
  task automatic step(input logic dv, input logic [7:0] db, input logic kl, output bit acc);
    bit kl_eff, nxt_issue;
    acc       = dv && !m_issue;
    kl_eff    = m_pend || kl;
    nxt_issue = 0;
    if (m_issue) begin
      m_loadkey = kl_eff;
      if (kl_eff) key_q.delete();
      m_pend = 0;
    end else begin
      if (m_loadkey) begin
        if (kl) key_q.delete();
        m_pend = 0;
      end else if (msg_q.size() == 0 && kl_eff) begin
        m_loadkey = 1;
        key_q.delete();
        m_pend = 0;
      end else begin
        m_pend = kl_eff;
      end
      if (acc) begin
        if (m_loadkey) begin
          key_q.push_back(db);
          if (key_q.size() == NKB) begin
            m_k = N_K'(pack(key_q));
            key_q.delete();
            m_loadkey = 0;
          end
        end else begin
          msg_q.push_back(db);
          if (msg_q.size() == NBB) begin
            m_m = N_B'(pack(msg_q));
            msg_q.delete();
            nxt_issue = 1;
            issue_q.push_back('{m_k, m_m, cyc + 1});
            rv_q.push_back(cyc + 1 + N_R + 1);
          end
        end
      end
    end
    m_issue = nxt_issue;
  endtask

  task automatic cycle(input logic dv, input logic [7:0] db, input logic kl, output bit acc);
    @(negedge clk);
    chk("d_ready", 128'(d_ready), 128'(!m_issue));
    chk("k_stable", 128'(k), 128'(m_k));
    chk("m_stable", 128'(m), 128'(m_m));
    d_valid = dv; d = db; kld = kl;
    c = {$urandom, $urandom};
    step(dv, db, kl, acc);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic kl);
    bit acc = 0;
    for (int t = 0; t < 4 && !acc; t++) cycle(1'b1, b, (t == 0) ? kl : 1'b0, acc);
    chk("send_byte_accept", 128'(acc), 128'(1));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1; d_valid = 0; kld = 0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_k", 128'(k), 0);
      chk("rst_m", 128'(m), 0);
      chk("rst_issue", 128'(issue), 0);
      chk("rst_r_valid", 128'(r_valid), 0);
    end
    rst = 0;
    rel_cyc = cyc;
  endtask

  // Monitor: every issue and every r_valid must match the next expected entry.
  initial forever begin
    @(posedge clk);
    #2;
    if (issue) begin
      if (issue_q.size() == 0) chk("issue_unexpected", 128'(issue), 0);
      else begin
        e = issue_q.pop_front();
        chk("issue_cycle", 128'(cyc), 128'(e.cyc));
        chk("issue_k", 128'(k), 128'(e.k));
        chk("issue_m", 128'(m), 128'(e.m));
      end
    end
    if (r_valid) begin
      if (rv_q.size() == 0) chk("r_valid_unexpected", 128'(r_valid), 0);
      else begin
        chk("r_valid_cycle", 128'(cyc), 128'(rv_q.pop_front()));
        chk("r_pass", 128'(r), 128'(c));
      end
    end
  end

  initial begin
    bit acc;
    logic [N_K-1:0] k_exp;
    logic [N_B-1:0] m_exp;
    apply_reset(3);

    for (int i = 0; i < NKB; i++) send_byte(8'(i), 1'b0);
    for (int i = 0; i < NBB; i++) send_byte(8'(i), 1'b0);
    idle(1);
`ifdef ENCRYPT_LOAD_LE_EN
    k_exp = 80'h09080706050403020100;
    m_exp = 64'h0706050403020100;
`else
    k_exp = 80'h00010203040506070809;
    m_exp = 64'h0001020304050607;
`endif
    chk("first_issue", 128'(issue), 1);
    chk("first_issue_at_19", 128'(cyc - rel_cyc), 19);
    chk("first_k", 128'(k), 128'(k_exp));
    chk("first_m", 128'(m), 128'(m_exp));

    // Reload request mid-message: block still issues, then the new key loads.
    for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1, acc);
    for (int i = 3; i < NBB; i++) send_byte(8'(8'h10 + i), 1'b0);
    for (int i = 0; i < NKB; i++) send_byte(8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < NBB; i++) send_byte(8'(8'h20 + i), 1'b0);

    // Four blocks streamed back to back.
    for (int i = 0; i < 4 * NBB; i++) send_byte(8'($urandom), 1'b0);
    idle(3);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 99) < 2, acc);

    for (int t = 0; t < 300 && !m_issue; t++) cycle($urandom_range(0, 9) < 8, 8'($urandom), 1'b0, acc);
    chk("issue_before_reset", 128'(m_issue), 1);
    idle(5);
    apply_reset(2);
    idle(N_R + 5);
    for (int i = 0; i < NKB + NBB; i++) send_byte(8'($urandom), 1'b0);
    idle(N_R + 8);
    chk("issue_q_drained", 128'(issue_q.size()), 0);
    chk("rv_q_drained", 128'(rv_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
